// File: rtl/wd_sup_pkg.sv
// Shared types and helpers for the watchdog supervisor: FSM state encoding and
// the full-scale gain helper.
package wd_sup_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REARM   = 3'd1,
    ARMED   = 3'd2,
    WARN    = 3'd3,
    RAMP    = 3'd4,
    HOLDOFF = 3'd5,
    LOCKOUT = 3'd6
  } wd_sup_state_t;

  function automatic int gain_full(input int gain_w);
    return (1 << gain_w) - 1;
  endfunction

endpackage

// File: rtl/wd_supervisor_gain_ramp.sv
// Saturating gain integrator: steps the carrier gain up or down by RAMP_STEP per
// clock, clamped to [0, full scale]. clear has priority over down, down over up.
module gain_ramp
  import wd_sup_pkg::*;
#(
  parameter int GAIN_W    = 8,
  parameter int RAMP_STEP = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              up,
  input  logic              down,
  input  logic              clear,
  output logic [GAIN_W-1:0] gain,
  output logic              at_zero,
  output logic              at_full
);

  localparam logic [GAIN_W:0] FULL_X = (GAIN_W+1)'(gain_full(GAIN_W));
  localparam logic [GAIN_W:0] STEP_X = (GAIN_W+1)'(RAMP_STEP);

  function automatic logic [GAIN_W-1:0] sat_up(input logic [GAIN_W-1:0] g);
    logic [GAIN_W:0] sum;
    sum = {1'b0, g} + STEP_X;
    if (sum > FULL_X) return FULL_X[GAIN_W-1:0];
    return sum[GAIN_W-1:0];
  endfunction

  // With the step no larger than full scale, an underflow always sets the extra
  // top bit, so it doubles as the borrow flag.
  function automatic logic [GAIN_W-1:0] sat_down(input logic [GAIN_W-1:0] g);
    logic [GAIN_W:0] diff;
    diff = {1'b0, g} - STEP_X;
    if (diff[GAIN_W]) return '0;
    return diff[GAIN_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      gain <= '0;
    end else if (clear) begin
      gain <= '0;
    end else if (down) begin
      gain <= sat_down(gain);
    end else if (up) begin
      gain <= sat_up(gain);
    end
  end

  assign at_zero = (gain == '0);
  assign at_full = (gain == FULL_X[GAIN_W-1:0]);

endmodule

// File: rtl/wd_supervisor.sv
// Supervisory FSM for the AM transmitter: arms the watchdog, forwards heartbeats,
// ramps carrier gain down on a trip, holds mute, re-arms, and latches lockout.
module wd_supervisor
  import wd_sup_pkg::*;
#(
  parameter int GAIN_W         = 8,
  parameter int RAMP_STEP      = 16,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int MAX_FAULTS     = 3,
  parameter int FAULT_W        = $clog2(MAX_FAULTS + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               arm,
  input  logic               host_heartbeat,
  input  logic               clear_fault,
  input  logic               wd_warning,
  input  logic               wd_triggered,
  output logic               wd_enable,
  output logic               wd_heartbeat,
  output logic               wd_force_reset,
  output logic [GAIN_W-1:0]  gain,
  output logic               rf_mute,
  output logic [FAULT_W-1:0] fault_count,
  output logic               lockout,
  output logic [2:0]         state
);

  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [FAULT_W-1:0] FAULT_MAX = FAULT_W'(MAX_FAULTS);

  wd_sup_state_t      state_q, state_d;
  logic               stop_req_q, stop_req_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [FAULT_W-1:0] fault_q, fault_d;
  logic               fault_inc;

  logic wd_enable_d, wd_force_reset_d, rf_mute_d, lockout_d, wd_heartbeat_d;
  logic ramp_up, ramp_down, ramp_clear, at_zero, at_full;

  gain_ramp #(
    .GAIN_W    (GAIN_W),
    .RAMP_STEP (RAMP_STEP)
  ) u_gain_ramp (
    .clk     (clk),
    .rstn    (rstn),
    .up      (ramp_up),
    .down    (ramp_down),
    .clear   (ramp_clear),
    .gain    (gain),
    .at_zero (at_zero),
    .at_full (at_full)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stop_req_d = stop_req_q;
    fault_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) state_d = REARM;
      end
      REARM: begin
        state_d = ARMED;
      end
      ARMED, WARN: begin
        if (wd_triggered) begin
          state_d = RAMP;
        end else if (!arm) begin
          state_d    = RAMP;
          stop_req_d = 1'b1;
        end else if (state_q == ARMED && wd_warning) begin
          state_d = WARN;
        end else if (state_q == WARN && !wd_warning) begin
          state_d = ARMED;
        end
      end
      RAMP: begin
        // A trip during a graceful stop turns it back into a counted fault.
        if (wd_triggered) stop_req_d = 1'b0;
        if (at_zero) begin
          stop_req_d = 1'b0;
          if (stop_req_q && !wd_triggered) begin
            state_d = IDLE;
          end else begin
            fault_inc = 1'b1;
            state_d   = HOLDOFF;
          end
        end
      end
      HOLDOFF: begin
        if (hold_cnt_q == HOLD_LAST) begin
          if (fault_q >= FAULT_MAX) state_d = LOCKOUT;
          else if (arm)             state_d = REARM;
          else                      state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (clear_fault) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state register.
  always_comb begin
    wd_enable_d      = 1'b0;
    wd_force_reset_d = 1'b0;
    rf_mute_d        = 1'b1;
    lockout_d        = 1'b0;
    ramp_up          = 1'b0;
    ramp_down        = 1'b0;
    ramp_clear       = 1'b0;
    case (state_d)
      REARM: begin
        wd_enable_d      = 1'b1;
        wd_force_reset_d = 1'b1;
        ramp_clear       = 1'b1;
      end
      ARMED, WARN: begin
        wd_enable_d = 1'b1;
        rf_mute_d   = 1'b0;
        ramp_up     = !at_full;
      end
      RAMP: begin
        wd_enable_d = 1'b1;
        rf_mute_d   = 1'b0;
        ramp_down   = 1'b1;
      end
      LOCKOUT: begin
        lockout_d  = 1'b1;
        ramp_clear = 1'b1;
      end
      default: begin
        ramp_clear = 1'b1;
      end
    endcase
    wd_heartbeat_d = host_heartbeat && (state_d == ARMED || state_d == WARN);
  end

  always_comb begin
    hold_cnt_d = '0;
    if (state_q == HOLDOFF && hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    fault_d = fault_q;
    if (clear_fault) fault_d = '0;
    else if (fault_inc && fault_q < FAULT_MAX) fault_d = fault_q + FAULT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stop_req_q     <= 1'b0;
      hold_cnt_q     <= '0;
      fault_q        <= '0;
      wd_enable      <= 1'b0;
      wd_heartbeat   <= 1'b0;
      wd_force_reset <= 1'b0;
      rf_mute        <= 1'b1;
      lockout        <= 1'b0;
    end else begin
      stop_req_q     <= stop_req_d;
      hold_cnt_q     <= hold_cnt_d;
      fault_q        <= fault_d;
      wd_enable      <= wd_enable_d;
      wd_heartbeat   <= wd_heartbeat_d;
      wd_force_reset <= wd_force_reset_d;
      rf_mute        <= rf_mute_d;
      lockout        <= lockout_d;
    end
  end

  assign state       = state_q;
  assign fault_count = fault_q;

endmodule

// File: tb/tb_wd_supervisor.sv
// Directed bench for wd_supervisor with GAIN_W=8, RAMP_STEP=64, HOLDOFF_CYCLES=4,
// MAX_FAULTS=2; expected values are hand-computed constants.
module tb_wd_supervisor;

  localparam int S_IDLE = 0, S_REARM = 1, S_ARMED = 2, S_WARN = 3;
  localparam int S_RAMP = 4, S_HOLDOFF = 5, S_LOCKOUT = 6;

  logic       clk = 1'b0;
  logic       rstn, arm, host_heartbeat, clear_fault, wd_warning, wd_triggered;
  logic       wd_enable, wd_heartbeat, wd_force_reset, rf_mute, lockout;
  logic [7:0] gain;
  logic [1:0] fault_count;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  wd_supervisor #(
    .GAIN_W         (8),
    .RAMP_STEP      (64),
    .HOLDOFF_CYCLES (4),
    .MAX_FAULTS     (2)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .arm            (arm),
    .host_heartbeat (host_heartbeat),
    .clear_fault    (clear_fault),
    .wd_warning     (wd_warning),
    .wd_triggered   (wd_triggered),
    .wd_enable      (wd_enable),
    .wd_heartbeat   (wd_heartbeat),
    .wd_force_reset (wd_force_reset),
    .gain           (gain),
    .rf_mute        (rf_mute),
    .fault_count    (fault_count),
    .lockout        (lockout),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_sg(input string tag, input int st, input int g);
    check_eq({tag, ".state"}, 32'(state), st);
    check_eq({tag, ".gain"}, 32'(gain), g);
  endtask

  task automatic expect_ctl(input string tag, input int en, input int mute, input int flt);
    check_eq({tag, ".wd_enable"}, 32'(wd_enable), en);
    check_eq({tag, ".rf_mute"}, 32'(rf_mute), mute);
    check_eq({tag, ".fault_count"}, 32'(fault_count), flt);
  endtask

  initial begin
    rstn = 1'b0; arm = 1'b0; host_heartbeat = 1'b0; clear_fault = 1'b0;
    wd_warning = 1'b0; wd_triggered = 1'b0;
    tick(2);
    expect_sg("reset", S_IDLE, 0);
    expect_ctl("reset", 0, 1, 0);
    check_eq("reset.force_reset", 32'(wd_force_reset), 0);
    check_eq("reset.lockout", 32'(lockout), 0);
    rstn = 1'b1;
    tick(1);

    // Heartbeat in IDLE must not reach the watchdog
    host_heartbeat = 1'b1;
    tick(1);
    host_heartbeat = 1'b0;
    check_eq("hb_idle", 32'(wd_heartbeat), 0);

    // Arm and soft-start
    arm = 1'b1;
    tick(1);
    expect_sg("rearm", S_REARM, 0);
    check_eq("rearm.force_reset", 32'(wd_force_reset), 1);
    check_eq("rearm.wd_enable", 32'(wd_enable), 1);
    tick(1);
    expect_sg("soft1", S_ARMED, 64);
    check_eq("soft1.force_reset", 32'(wd_force_reset), 0);
    check_eq("soft1.rf_mute", 32'(rf_mute), 0);
    tick(1); expect_sg("soft2", S_ARMED, 128);
    tick(1); expect_sg("soft3", S_ARMED, 192);
    tick(1); expect_sg("soft4", S_ARMED, 255);
    tick(1); expect_sg("soft_hold", S_ARMED, 255);

    // Heartbeat forwarded one cycle later, for one cycle
    host_heartbeat = 1'b1;
    tick(1);
    host_heartbeat = 1'b0;
    check_eq("hb_armed", 32'(wd_heartbeat), 1);
    tick(1);
    check_eq("hb_armed_after", 32'(wd_heartbeat), 0);

    // Warning served
    wd_warning = 1'b1;
    tick(1);
    expect_sg("warn", S_WARN, 255);
    wd_warning = 1'b0;
    tick(1);
    expect_sg("warn_clr", S_ARMED, 255);
    check_eq("warn_clr.fault_count", 32'(fault_count), 0);

    // First trip, ramp-down, holdoff, re-arm
    wd_triggered = 1'b1;
    tick(1);
    wd_triggered = 1'b0;
    expect_sg("trip1.r1", S_RAMP, 191);
    tick(1); expect_sg("trip1.r2", S_RAMP, 127);
    tick(1); expect_sg("trip1.r3", S_RAMP, 63);
    tick(1); expect_sg("trip1.r4", S_RAMP, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      expect_sg("trip1.hold", S_HOLDOFF, 0);
      expect_ctl("trip1.hold", 0, 1, 1);
    end
    tick(1);
    expect_sg("trip1.rearm", S_REARM, 0);
    check_eq("trip1.rearm.force_reset", 32'(wd_force_reset), 1);
    tick(1); expect_sg("trip1.soft1", S_ARMED, 64);
    tick(3); expect_sg("trip1.soft4", S_ARMED, 255);

    // Graceful stop keeps the fault count
    arm = 1'b0;
    tick(1); expect_sg("stop.r1", S_RAMP, 191);
    tick(3); expect_sg("stop.r4", S_RAMP, 0);
    tick(1);
    expect_sg("stop.idle", S_IDLE, 0);
    expect_ctl("stop.idle", 0, 1, 1);

    // Second trip reaches lockout
    arm = 1'b1;
    tick(5);
    expect_sg("arm2", S_ARMED, 255);
    wd_triggered = 1'b1;
    tick(1);
    wd_triggered = 1'b0;
    expect_sg("trip2.r1", S_RAMP, 191);
    tick(3);
    expect_sg("trip2.r4", S_RAMP, 0);
    tick(1);
    check_eq("trip2.fault_count", 32'(fault_count), 2);
    tick(4);
    expect_sg("lock", S_LOCKOUT, 0);
    expect_ctl("lock", 0, 1, 2);
    check_eq("lock.lockout", 32'(lockout), 1);
    tick(3);
    expect_sg("lock_arm_ignored", S_LOCKOUT, 0);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    expect_sg("clear", S_IDLE, 0);
    check_eq("clear.fault_count", 32'(fault_count), 0);
    check_eq("clear.lockout", 32'(lockout), 0);

    // Trip arriving while a stop request is pending counts as a fault
    tick(2);
    expect_sg("arm3", S_ARMED, 64);
    arm = 1'b0;
    tick(1);
    expect_sg("stop3", S_RAMP, 0);
    wd_triggered = 1'b1;
    tick(1);
    wd_triggered = 1'b0;
    expect_sg("stop_trip", S_HOLDOFF, 0);
    check_eq("stop_trip.fault_count", 32'(fault_count), 1);
    tick(4);
    expect_sg("stop_trip.idle", S_IDLE, 0);

    // Reset in the middle of a ramp
    arm = 1'b1;
    tick(2);
    expect_sg("arm4", S_ARMED, 64);
    wd_triggered = 1'b1;
    tick(1);
    wd_triggered = 1'b0;
    expect_sg("trip4", S_RAMP, 0);
    check_eq("trip4.wd_enable", 32'(wd_enable), 1);
    rstn = 1'b0;
    tick(1);
    expect_sg("mid_reset", S_IDLE, 0);
    expect_ctl("mid_reset", 0, 1, 0);
    rstn = 1'b1;
    arm = 1'b0;
    tick(1);
    expect_sg("post_reset", S_IDLE, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wd_supervisor.md
Name: wd_supervisor

Overview:
Supervisory controller that sequences the watchdog_timer and the RF output gain for the AM transmitter. It arms the watchdog and forwards host heartbeats to it. When the watchdog fires, it ramps the carrier gain down, holds mute, and re-arms. After repeated faults it latches a lockout that only an explicit host clear releases. It sits between the host/SCPI control logic, the watchdog_timer instance and the modulator gain input.

Parameters:
GAIN_W, 8, width of output gain word; full scale = 2^GAIN_W-1
RAMP_STEP, 16, gain increment/decrement per clk during soft-start and ramp-down
HOLDOFF_CYCLES, 1000, mute hold time after ramp-down before re-arm
MAX_FAULTS, 3, fault count at which LOCKOUT is entered
FAULT_W, $clog2(MAX_FAULTS+1), width of fault counter

Ports:
clk  in  1  system clock
rstn  in  1  reset, synchronous, active-low
arm  in  1  level; host requests supervised transmission
host_heartbeat  in  1  1-cycle pet pulse from host
clear_fault  in  1  1-cycle pulse; clears fault_count and releases LOCKOUT
wd_warning  in  1  from watchdog_timer.warning
wd_triggered  in  1  from watchdog_timer.triggered
wd_enable  out  1  to watchdog_timer.enable
wd_heartbeat  out  1  to watchdog_timer.heartbeat
wd_force_reset  out  1  to watchdog_timer.force_reset
gain  out  GAIN_W  modulator output gain
rf_mute  out  1  hard mute to RF stage
fault_count  out  FAULT_W  saturating count of watchdog trips
lockout  out  1  high in LOCKOUT
state  out  3  current FSM state, for status readback

Behaviour:
- All outputs registered. Reset (rstn=0 at a clk edge) gives: state=IDLE, gain=0, rf_mute=1, wd_enable=0, wd_heartbeat=0, wd_force_reset=0, fault_count=0, lockout=0, stop_req=0, holdoff counter=0. Reset mid-operation behaves identically.
- States: IDLE, REARM, ARMED, WARN, RAMP, HOLDOFF, LOCKOUT.
- IDLE: wd_enable=0, gain=0, rf_mute=1. arm=1 -> REARM.
- REARM: exactly one cycle. wd_force_reset=1, wd_enable=1. Next state is ARMED.
- ARMED: wd_enable=1, rf_mute=0. gain soft-starts by +RAMP_STEP per cycle, saturating at full scale (no wrap). Transitions in priority order:
  - wd_triggered -> RAMP (fault).
  - arm=0 -> RAMP with stop_req=1.
  - wd_warning -> WARN.
- WARN: same outputs as ARMED. Transitions in priority order:
  - wd_triggered -> RAMP (fault).
  - arm=0 -> RAMP with stop_req=1.
  - wd_warning=0 -> ARMED.
- wd_heartbeat = host_heartbeat registered, 1-cycle latency, gated to 0 in every state except ARMED and WARN.
- RAMP: wd_enable=1, heartbeat suppressed, rf_mute=0. gain decreases by RAMP_STEP per cycle, saturating at 0. In the cycle gain becomes 0:
  - if stop_req=1: go to IDLE and clear stop_req; fault_count unchanged.
  - otherwise: increment fault_count (saturating at MAX_FAULTS) and go to HOLDOFF.
  - A trigger arriving with stop_req already set still counts as a fault: wd_triggered on entry clears stop_req.
- HOLDOFF: rf_mute=1, gain=0, wd_enable=0. Counter runs 0..HOLDOFF_CYCLES-1. On the last count:
  - if fault_count>=MAX_FAULTS -> LOCKOUT;
  - else if arm=1 -> REARM;
  - else -> IDLE.
- LOCKOUT: lockout=1, rf_mute=1, gain=0, wd_enable=0. arm is ignored. clear_fault -> IDLE.
- clear_fault in any state zeroes fault_count. If it coincides with a fault increment, the clear wins.
- wd_triggered while in IDLE, HOLDOFF or LOCKOUT is ignored.
- Gain arithmetic is done at GAIN_W+1 bits, then clamped to [0, full scale].

Decomposition:
- Package wd_sup_pkg holds:
  - state enum wd_sup_state_t with fixed encodings IDLE=0, REARM=1, ARMED=2, WARN=3, RAMP=4, HOLDOFF=5, LOCKOUT=6;
  - function gain_full(GAIN_W).
- One sub-module, gain_ramp:
  - inputs up, down, clear; output gain;
  - handles saturating ±RAMP_STEP and asserts at_zero/at_full flags.
- The FSM, holdoff counter and fault counter stay in wd_supervisor.

Test Plan:
Bench parameters: GAIN_W=8, RAMP_STEP=64, HOLDOFF_CYCLES=4, MAX_FAULTS=2.
1. Arm and soft-start: release reset, assert arm=1 -> REARM for one cycle with wd_force_reset=1 and wd_enable=1; then ARMED with gain 64, 128, 192, 255 and holding at 255.
2. Heartbeat gating: host_heartbeat pulse in ARMED -> wd_heartbeat=1 exactly one cycle later. The same pulse in IDLE -> wd_heartbeat stays 0.
3. Warning served: wd_warning=1 -> state WARN; wd_warning=0 -> ARMED; gain stays 255 and fault_count stays 0.
4. Trip and recovery: wd_triggered at gain=255 -> gain 191, 127, 63, 0 and fault_count=1. Then HOLDOFF for 4 cycles with rf_mute=1 and wd_enable=0, then REARM pulse, then ARMED soft-start.
5. Lockout: second trip -> fault_count=2 -> LOCKOUT with lockout=1. arm stays ignored. clear_fault pulse -> IDLE with fault_count=0 and lockout=0.
6. Graceful stop and reset: arm=0 in ARMED at gain 255 -> ramp to 0 -> IDLE with fault_count unchanged. rstn=0 during RAMP -> next edge gives IDLE, gain=0, wd_enable=0, fault_count=0.
